// File: rtl/ga25_sdr_responder.sv
// ga25_sdr_responder: responder end of the GFX SDRAM request interface.
// Takes single-cycle 32/64-bit read requests, splits them into pipelined
// 16-bit memory reads, reassembles the halfwords little-endian and returns
// the result with a one-cycle sdr_rdy pulse. One request can wait in a
// pending slot while another is in service; anything beyond that is dropped
// and flagged on the sticky sdr_ovf output.
module ga25_sdr_responder #(
    parameter int ADDR_W          = 25,
    parameter int MEM_AW          = 24,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] sdr_addr,
    input  logic              sdr_req,
    input  logic              sdr_64bit,
    output logic [63:0]       sdr_data,
    output logic              sdr_rdy,
    output logic              sdr_ovf,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_busy,
    input  logic [15:0]       mem_q,
    input  logic              mem_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_reg, state_next;

    // Pending request slot (halfword address only; byte lane bit is ignored)
    logic              slot_full_reg;
    logic [MEM_AW-1:0] slot_addr_reg;
    logic              slot_64_reg;

    // Active transfer bookkeeping
    logic [MEM_AW-1:0] base_reg;
    logic [2:0]        total_reg;
    logic [2:0]        issue_cnt_reg;
    logic [2:0]        ret_cnt_reg;
    logic [15:0]       lane_reg [4];
    logic [63:0]       data_reg;
    logic              ovf_reg;

    logic              start;
    logic              throttle;
    logic              accept;
    logic              last_issue;
    logic              capture;
    logic              collect_done;
    logic [2:0]        outstanding;
    logic              addr_lsb_unused;

    // Byte address bit 0 has no meaning for halfword reads
    assign addr_lsb_unused = sdr_addr[0];

    // Handshake and progress decodes shared by the FSM and the datapath
    always_comb begin
        start        = (state_reg == IDLE) && slot_full_reg;
        outstanding  = issue_cnt_reg - ret_cnt_reg;
        throttle     = (outstanding == 3'(MAX_OUTSTANDING));
        accept       = (state_reg == ISSUE) && !throttle && !mem_busy;
        last_issue   = accept && (issue_cnt_reg == (total_reg - 3'd1));
        capture      = mem_valid && (state_reg != IDLE) && (ret_cnt_reg != total_reg);
        collect_done = (state_reg == COLLECT) && (ret_cnt_reg == total_reg);
    end

    // State register; reset drops mem_rd at once because mem_rd decodes state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and memory/handshake outputs
    always_comb begin
        state_next = state_reg;
        mem_rd     = 1'b0;
        sdr_rdy    = 1'b0;
        mem_addr   = base_reg + MEM_AW'(issue_cnt_reg);
        case (state_reg)
            IDLE: begin
                if (slot_full_reg) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_rd = !throttle;
                if (last_issue) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (collect_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                sdr_rdy    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pending slot: a slot emptied this cycle can take a new request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_full_reg <= 1'b0;
            slot_addr_reg <= '0;
            slot_64_reg   <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            if (sdr_req && (!slot_full_reg || start)) begin
                slot_full_reg <= 1'b1;
                slot_addr_reg <= sdr_addr[ADDR_W-1:1];
                slot_64_reg   <= sdr_64bit;
            end else if (start) begin
                slot_full_reg <= 1'b0;
            end
            if (sdr_req && slot_full_reg && !start) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Transfer counters; base address arithmetic wraps naturally at MEM_AW bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_reg      <= '0;
            total_reg     <= 3'd0;
            issue_cnt_reg <= 3'd0;
            ret_cnt_reg   <= 3'd0;
        end else if (start) begin
            base_reg      <= slot_addr_reg;
            total_reg     <= slot_64_reg ? 3'd4 : 3'd2;
            issue_cnt_reg <= 3'd0;
            ret_cnt_reg   <= 3'd0;
        end else begin
            if (accept) begin
                issue_cnt_reg <= issue_cnt_reg + 3'd1;
            end
            if (capture) begin
                ret_cnt_reg <= ret_cnt_reg + 3'd1;
            end
        end
    end

    // Assembly lanes: returns land in order, lane n holds halfword n
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            // Clear at transfer start so unused upper lanes read as zero
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    lane_reg[gi] <= 16'h0000;
                end else if (start) begin
                    lane_reg[gi] <= 16'h0000;
                end else if (capture && (ret_cnt_reg[1:0] == 2'(gi))) begin
                    lane_reg[gi] <= mem_q;
                end
            end
        end
    endgenerate

    // Result register, loaded as DONE is entered and held until the next one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= 64'h0;
        end else if (collect_done) begin
            data_reg <= {lane_reg[3], lane_reg[2], lane_reg[1], lane_reg[0]};
        end
    end

    assign sdr_data = data_reg;
    assign sdr_ovf  = ovf_reg;

endmodule

// File: tb/tb_ga25_sdr_responder.sv
// Bench for ga25_sdr_responder: a pipelined memory model answering one cycle
// after each accepted beat, table-driven single reads, plus hand sequences for
// backpressure, overflow and reset during a transfer.
module tb_ga25_sdr_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [24:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_64bit;
    logic [63:0] sdr_data;
    logic        sdr_rdy;
    logic        sdr_ovf;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic        mem_busy;
    logic [15:0] mem_q;
    logic        mem_valid;

    always #5 clk = ~clk;

    ga25_sdr_responder #(
        .ADDR_W(25),
        .MEM_AW(24),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sdr_addr (sdr_addr),
        .sdr_req  (sdr_req),
        .sdr_64bit(sdr_64bit),
        .sdr_data (sdr_data),
        .sdr_rdy  (sdr_rdy),
        .sdr_ovf  (sdr_ovf),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_busy (mem_busy),
        .mem_q    (mem_q),
        .mem_valid(mem_valid)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cyc = 0;
    int rdy_cyc = 0;
    int rdy_cnt = 0;
    logic [63:0] last_data = 64'h0;
    logic [63:0] rdy_q[$];
    logic [23:0] acc_q[$];
    logic        force_valid = 1'b0;
    logic        pend;
    logic [23:0] paddr;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        case (a)
            24'h000082: return 16'h1111;
            24'h000083: return 16'h2222;
            24'h000100: return 16'h00A0;
            24'h000101: return 16'h00A1;
            24'h000102: return 16'h00A2;
            24'h000103: return 16'h00A3;
            default:    return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    // Memory model and rdy monitor: sample at negedge, answer next cycle
    initial begin
        mem_valid = 1'b0;
        mem_q     = 16'h0;
        forever begin
            @(negedge clk);
            pend  = mem_rd && !mem_busy;
            paddr = mem_addr;
            if (pend) acc_q.push_back(paddr);
            if (sdr_rdy) begin
                rdy_cnt++;
                last_data = sdr_data;
                rdy_cyc   = cyc;
                rdy_q.push_back(sdr_data);
            end
            @(posedge clk);
            #2;
            mem_valid = pend || force_valid;
            mem_q     = force_valid ? 16'hDEAD : mem_word(paddr);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [24:0] a, input logic is64);
        step();
        sdr_addr  = a;
        sdr_64bit = is64;
        sdr_req   = 1'b1;
        req_cyc   = cyc;
        step();
        sdr_req   = 1'b0;
    endtask

    task automatic wait_rdy(input int target, input int budget, input string name);
        int n = 0;
        while (rdy_cnt < target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (rdy_cnt < target) begin
            errors++;
            $display("FAIL %s: timeout, rdy count %0d expected %0d", name, rdy_cnt, target);
        end
    endtask

    typedef struct {
        logic [24:0] addr;
        logic        is64;
        logic [63:0] exp_data;
        int          exp_lat;
        logic [23:0] exp_a0;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v, input string name);
        int r0;
        int beats;
        logic [23:0] ea;
        beats = v.is64 ? 4 : 2;
        acc_q.delete();
        r0 = rdy_cnt;
        issue(v.addr, v.is64);
        wait_rdy(r0 + 1, 40, name);
        repeat (4) step();
        $display("txn %s addr=0x%07h 64b=%0b data=0x%016h lat=%0d beats=%0d",
                 name, v.addr, v.is64, last_data, rdy_cyc - req_cyc, acc_q.size());
        chk({name, " data"}, last_data, v.exp_data);
        chk({name, " latency"}, 64'(rdy_cyc - req_cyc), 64'(v.exp_lat));
        chk({name, " rdy count"}, 64'(rdy_cnt - r0), 64'd1);
        chk({name, " beat count"}, 64'(acc_q.size()), 64'(beats));
        for (int i = 0; i < beats && i < acc_q.size(); i++) begin
            ea = v.exp_a0 + 24'(i);
            chk({name, " mem_addr"}, 64'(acc_q[i]), 64'(ea));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        vecs[0] = '{25'h0000104, 1'b0, 64'h0000000022221111, 6, 24'h000082};
        vecs[1] = '{25'h0000200, 1'b1, 64'h00A300A200A100A0, 8, 24'h000100};
        vecs[2] = '{25'h0000105, 1'b0, 64'h0000000022221111, 6, 24'h000082};
        vecs[3] = '{25'h1FFFFFC, 1'b1, 64'h5A5B5A5AA5A5A5A4, 8, 24'hFFFFFE};
        vecs[4] = '{25'h1FFFFFE, 1'b0, 64'h000000005A5AA5A5, 6, 24'hFFFFFF};

        reset_n   = 1'b0;
        sdr_addr  = '0;
        sdr_req   = 1'b0;
        sdr_64bit = 1'b0;
        mem_busy  = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("reset sdr_data", sdr_data, 64'h0);
        chk("reset sdr_rdy", 64'(sdr_rdy), 64'd0);
        chk("reset sdr_ovf", 64'(sdr_ovf), 64'd0);
        chk("reset mem_addr", 64'(mem_addr), 64'd0);
        chk("reset mem_rd", 64'(mem_rd), 64'd0);
        step();
        reset_n = 1'b1;
        repeat (2) step();

        // Table-driven single reads
        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Backpressure on the second beat of a 64-bit read
        acc_q.delete();
        r0 = rdy_cnt;
        issue(25'h0000200, 1'b1);
        step();
        step();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy mem_addr hold", 64'(mem_addr), 64'h101);
            chk("busy mem_rd hold", 64'(mem_rd), 64'd1);
            step();
        end
        mem_busy = 1'b0;
        wait_rdy(r0 + 1, 40, "busy");
        repeat (4) step();
        $display("txn busy addr=0x0000200 64b=1 data=0x%016h lat=%0d beats=%0d",
                 last_data, rdy_cyc - req_cyc, acc_q.size());
        chk("busy data", last_data, 64'h00A300A200A100A0);
        chk("busy latency", 64'(rdy_cyc - req_cyc), 64'd11);
        chk("busy beat count", 64'(acc_q.size()), 64'd4);
        chk("busy rdy count", 64'(rdy_cnt - r0), 64'd1);
        chk("ovf still clear", 64'(sdr_ovf), 64'd0);

        // Three back-to-back requests: first served, second pending, third dropped
        rdy_q.delete();
        r0 = rdy_cnt;
        step();
        sdr_addr = 25'h0000104; sdr_64bit = 1'b0; sdr_req = 1'b1;
        step();
        sdr_addr = 25'h0000200; sdr_64bit = 1'b1; sdr_req = 1'b1;
        step();
        sdr_addr = 25'h0000000; sdr_64bit = 1'b0; sdr_req = 1'b1;
        step();
        sdr_req = 1'b0;
        wait_rdy(r0 + 2, 60, "ovf");
        repeat (20) step();
        $display("txn ovf rdy_pulses=%0d ovf=%0b", rdy_cnt - r0, sdr_ovf);
        chk("ovf rdy count", 64'(rdy_cnt - r0), 64'd2);
        chk("ovf sticky", 64'(sdr_ovf), 64'd1);
        if (rdy_q.size() >= 2) begin
            chk("ovf first data", rdy_q[0], 64'h0000000022221111);
            chk("ovf second data", rdy_q[1], 64'h00A300A200A100A0);
        end else begin
            chk("ovf rdy_q size", 64'(rdy_q.size()), 64'd2);
        end

        // Reset during COLLECT with returns still arriving
        r0 = rdy_cnt;
        issue(25'h0000200, 1'b1);
        repeat (5) step();
        force_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset mem_rd", 64'(mem_rd), 64'd0);
        chk("midreset sdr_rdy", 64'(sdr_rdy), 64'd0);
        chk("midreset sdr_data", sdr_data, 64'h0);
        chk("midreset mem_addr", 64'(mem_addr), 64'd0);
        chk("midreset sdr_ovf", 64'(sdr_ovf), 64'd0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (4) step();
        force_valid = 1'b0;
        repeat (6) step();
        $display("txn midreset rdy_pulses=%0d", rdy_cnt - r0);
        chk("midreset no rdy", 64'(rdy_cnt - r0), 64'd0);
        run_vec(vecs[0], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ga25_sdr_responder.md
Name: ga25_sdr_responder

Overview:
- Responder end of the GFX SDRAM request interface. Accepts single-cycle read requests (byte address, 32/64-bit size) from the GFX arbiter.
- Splits each request into 16-bit reads on a pipelined memory port, assembles the result and returns it with a one-cycle ready pulse.
- Sits between the GFX arbiter and the board SDRAM controller port; also used as the bench-side memory model front end.

Parameters:
- ADDR_W, 25, request byte-address width.
- MEM_AW, 24, memory port halfword-address width (= ADDR_W-1).
- MAX_OUTSTANDING, 4, maximum memory reads issued but not yet returned (2..7).

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous active-low reset.
- sdr_addr  in  25  request byte address; bit 0 ignored.
- sdr_req  in  1  one-cycle request strobe; address and size sampled on this cycle.
- sdr_64bit  in  1  1 = 64-bit read (4 beats), 0 = 32-bit read (2 beats).
- sdr_data  out  64  returned data; held until the next sdr_rdy.
- sdr_rdy  out  1  one-cycle pulse, sdr_data valid on the same cycle.
- sdr_ovf  out  1  sticky: a request was dropped; cleared only by reset.
- mem_addr  out  24  halfword address.
- mem_rd  out  1  read strobe; a beat is accepted on a cycle with mem_rd & ~mem_busy.
- mem_busy  in  1  backpressure; mem_rd/mem_addr are held stable while it is high.
- mem_q  in  16  read data.
- mem_valid  in  1  mem_q valid; returns are in order, one per accepted beat.

Behaviour:
- Reset values: sdr_data=0, sdr_rdy=0, sdr_ovf=0, mem_addr=0, mem_rd=0. State is IDLE, pending slot is empty, counters are 0.
- Pending slot: one entry (addr, 64bit).
  - sdr_req while the slot is empty: capture into the slot.
  - sdr_req while the slot is full: drop the request, set sdr_ovf.
  - A slot freed on the same cycle as sdr_req accepts the new request; it is not dropped.
- States:
  - IDLE -> ISSUE when the slot is full. On that edge: base = addr[24:1], total beats = 4 if 64bit else 2, issue_cnt=0, ret_cnt=0, slot freed.
  - ISSUE:
    - mem_rd=1, mem_addr=base+issue_cnt.
    - issue_cnt increments on each accepted beat.
    - mem_rd drops for a cycle when (issue_cnt - ret_cnt) == MAX_OUTSTANDING.
    - After the last beat is accepted: -> COLLECT.
  - COLLECT: wait until ret_cnt == total -> DONE.
  - DONE: load sdr_data, pulse sdr_rdy for one cycle -> IDLE. If the slot is full, IDLE -> ISSUE on the next cycle.
- Return capture (any state except IDLE): each mem_valid writes mem_q into halfword lane ret_cnt of the assembly register, then ret_cnt increments.
  - Lane 0 = bits [15:0], lane 1 = [31:16], and so on (little-endian).
  - For 32-bit requests, sdr_data[63:32] = 0.
- Address arithmetic: halfword address base+n is computed modulo 2^24; wrap from 0xFFFFFF to 0x000000 is legal.
- Latency with no backpressure and mem_valid one cycle after acceptance. Cycle 0 = sdr_req:
  - cycle 1: slot full.
  - cycle 2: state ISSUE.
  - 32-bit: rdy at cycle 6.
  - 64-bit: rdy at cycle 8.
- mem_valid in IDLE (including stale returns after reset) is ignored.
- Reset mid-operation: mem_rd deasserts immediately (asynchronously), in-flight data is discarded and no sdr_rdy is issued.
- sdr_req and sdr_rdy on the same cycle is legal; the new request goes to the slot.

Test Plan:
- 32-bit read at addr 0x000104, memory returns 0x1111, 0x2222 -> mem_addr 0x000082, 0x000083; sdr_data=0x0000000022221111; one sdr_rdy at cycle 6.
- 64-bit read at 0x000200, returns 0xA0..0xA3 -> mem_addr 0x100..0x103; sdr_data=0x00A300A200A100A0; sdr_rdy at cycle 8.
- mem_busy high for 3 cycles during the second beat of a 64-bit read -> mem_addr holds 0x101 stable, no duplicate beats, data correct, rdy delayed 3 cycles.
- Three sdr_req pulses on consecutive cycles while busy -> first served, second pending and served next, third dropped; sdr_ovf=1; exactly 2 sdr_rdy pulses.
- 64-bit read at 0x1FFFFFC -> mem_addr 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- reset_n low mid-COLLECT while mem_valid pulses continue -> no sdr_rdy, all outputs at reset values; the next request returns correct data.
